// File: rtl/sub16_pkg.sv
// Purpose : shared widths, FSM state encoding and reset constants for the 16-bit sequential subtractor.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package sub16_pkg;

    localparam int WORD_W  = 16;
    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] D_RST = '0;

endpackage

// File: rtl/seq_subtractor_16_if.sv
// Purpose : start/done request bus for seq_subtractor_16 (operands in, registered difference and flags out).
// Latency : n/a (wiring only).
// Backpressure: none; requester must only raise start while busy is low for it to be taken.
// Signals : start, a, b, bin (requester -> subtractor); busy, done, d, borrow, zero, ovf (subtractor -> requester).
interface seq_subtractor_16_if;
    import sub16_pkg::*;

    logic              start;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              bin;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] d;
    logic              borrow;
    logic              zero;
    logic              ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, borrow, zero, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, borrow, zero, ovf
    );

endinterface

// File: rtl/sub_slice_8.sv
// Purpose : combinational 8-bit subtract slice, d = a - b - bin with borrow-out.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : a_i[7:0], b_i[7:0], bin_i -> d_o[7:0], bout_o.
module sub_slice_8
    import sub16_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               bin_i,
    output logic [SLICE_W-1:0] d_o,
    output logic               bout_o
);

    // a - b - bin == a + ~b + ~bin in two's complement; the carry out of
    // the 9-bit sum is the inverted borrow.
    logic [SLICE_W:0] sum;
    logic             bout_n;

    assign sum             = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE_W{1'b0}}, ~bin_i};
    assign {bout_n, d_o}   = sum;
    assign bout_o          = ~bout_n;

endmodule

// File: rtl/seq_subtractor_16.sv
// Purpose : 16-bit a - b - bin computed in two passes through one shared 8-bit slice (low byte, then high byte).
// Latency : 2 cycles from the accepting edge to done; one operation per 3 cycles at best.
// Backpressure: start is ignored while busy; no stall once accepted.
// Ports   : clk, rst (sync, active-high); bus (slave modport: start/a/b/bin in, busy/done/d/borrow/zero/ovf out).
module seq_subtractor_16
    import sub16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    seq_subtractor_16_if.slave   bus
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] a_q, b_q;
    logic              bin_q;
    logic              brw_q;      // borrow carried from the low pass to the high pass
    logic [WORD_W-1:0] d_q;
    logic              borrow_q, zero_q, ovf_q, done_q;

    logic              op_load, lo_we, hi_we;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_d;
    logic              sl_bin, sl_bout;

    // Slice operand muxes: the high byte is only selected in HIGH, otherwise
    // the low byte and external borrow-in feed the slice.
    always_comb begin
        sl_a   = a_q[SLICE_W-1:0];
        sl_b   = b_q[SLICE_W-1:0];
        sl_bin = bin_q;
        if (state_q == HIGH) begin
            sl_a   = a_q[WORD_W-1:SLICE_W];
            sl_b   = b_q[WORD_W-1:SLICE_W];
            sl_bin = brw_q;
        end
    end

    sub_slice_8 u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .bin_i  (sl_bin),
        .d_o    (sl_d),
        .bout_o (sl_bout)
    );

    always_comb begin
        state_d = state_q;
        op_load = 1'b0;
        lo_we   = 1'b0;
        hi_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_load = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                lo_we   = 1'b1;
                state_d = HIGH;
            end
            HIGH: begin
                hi_we   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            bin_q    <= 1'b0;
            brw_q    <= 1'b0;
            d_q      <= D_RST;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= hi_we;
            if (op_load) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                bin_q <= bus.bin;
            end
            if (lo_we) begin
                d_q[SLICE_W-1:0] <= sl_d;
                brw_q            <= sl_bout;
            end
            if (hi_we) begin
                d_q[WORD_W-1:SLICE_W] <= sl_d;
                borrow_q              <= sl_bout;
                zero_q                <= ({sl_d, d_q[SLICE_W-1:0]} == '0);
                // Signed overflow only possible when operand signs differ and
                // the result sign departs from the minuend's.
                ovf_q                 <= (a_q[WORD_W-1] != b_q[WORD_W-1]) &&
                                         (sl_d[SLICE_W-1] != a_q[WORD_W-1]);
            end
        end
    end

    assign bus.busy   = (state_q == LOW) || (state_q == HIGH);
    assign bus.done   = done_q;
    assign bus.d      = d_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
    assign bus.ovf    = ovf_q;

endmodule
